sdpram_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer in front of the 64x32 simple dual-port RAM wrapper (registered inputs, 2-cycle RAM read, registered output).
- Write port and read port are arbitrated independently with valid/ready handshakes.
- A fixed-latency tag pipeline routes each read result back to the requester that issued it.
- Same-address write/read collisions are resolved by deferring the read.

---
 rtl/sdpram_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_sdpram_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sdpram_arbiter.sv
// sdpram_arbiter
// ---------------------------------------------------------------------------
// Two-requester round-robin arbiter and sequencer in front of a 64x32 simple
// dual-port RAM wrapper. The write port and the read port are arbitrated
// independently. A fixed-depth tag pipeline follows each read through the
// RAM and steers the returned word back to the requester that issued it.
// When the granted write and the candidate read hit the same address in the
// same cycle, the write goes first and the read is held off by one cycle, so
// it returns the freshly written data.
//
// Parameters
//   ADDR_W      RAM address width
//   DATA_W      RAM data width
//   RD_LATENCY  cycles from ram_enb/ram_addrb to ram_doutb valid (>= 2)
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   wr_valid/wr_ready   per-requester write handshake (ready one-hot or zero)
//   wr_addr/wr_data     packed per-requester write address/data, slice i
//   rd_valid/rd_ready   per-requester read handshake (ready one-hot or zero)
//   rd_addr             packed per-requester read address, slice i
//   rd_rvalid           one-hot read-return strobe
//   rd_rdata            shared read-return data, 0 when no return is active
//   ram_ena/ram_wea     RAM port-A enable / write enable
//   ram_addra/ram_dina  RAM port-A address / write data
//   ram_enb/ram_addrb   RAM port-B enable / address
//   ram_doutb           RAM port-B read data
//
// Optional feature (macro SDPRAM_ARB_STATS_EN)
//   Adds saturating 16-bit counters wr_grant_cnt0/1, rd_grant_cnt0/1 and
//   collision_cnt, cleared by rst. Absent when the macro is not defined.
// ---------------------------------------------------------------------------
module sdpram_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            wr_valid,
  output logic [1:0]            wr_ready,
  input  logic [2*ADDR_W-1:0]   wr_addr,
  input  logic [2*DATA_W-1:0]   wr_data,
  input  logic [1:0]            rd_valid,
  output logic [1:0]            rd_ready,
  input  logic [2*ADDR_W-1:0]   rd_addr,
  output logic [1:0]            rd_rvalid,
  output logic [DATA_W-1:0]     rd_rdata,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_W-1:0]     ram_addra,
  output logic [DATA_W-1:0]     ram_dina,
  output logic                  ram_enb,
  output logic [ADDR_W-1:0]     ram_addrb,
  input  logic [DATA_W-1:0]     ram_doutb
`ifdef SDPRAM_ARB_STATS_EN
  ,
  output logic [15:0]           wr_grant_cnt0,
  output logic [15:0]           wr_grant_cnt1,
  output logic [15:0]           rd_grant_cnt0,
  output logic [15:0]           rd_grant_cnt1,
  output logic [15:0]           collision_cnt
`endif
);

  // Two-way round robin: a lone requester always wins; under contention the
  // requester that did not win last time is chosen. 'last' is the id of the
  // most recent grant on this port.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic [1:0] gnt;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    return gnt;
  endfunction

  // Saturating increment for the statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
    logic [15:0] nxt;
    if (cnt == 16'hFFFF) nxt = cnt;
    else                 nxt = cnt + 16'd1;
    return nxt;
  endfunction

  // Last-grant pointers. Reset to 1 so requester 0 wins the first contention.
  logic wr_last;
  logic rd_last;

  // Combinational arbitration results.
  logic [1:0]        wr_gnt;
  logic              wr_gid;
  logic [ADDR_W-1:0] wr_gaddr;
  logic [DATA_W-1:0] wr_gdata;
  logic [1:0]        rd_cand;
  logic              rd_cid;
  logic [ADDR_W-1:0] rd_caddr;
  logic              collision;
  logic [1:0]        rd_gnt;

  // Read tag pipeline: valid bits are control and get reset, ids are data.
  logic [RD_LATENCY-1:0] tag_vld_p;
  logic [RD_LATENCY-1:0] tag_id_p;
  logic                  tail_vld;
  logic                  tail_id;

  always_comb begin
    wr_gnt    = 2'b00;
    rd_cand   = 2'b00;
    if (!rst) begin
      wr_gnt  = rr_pick(wr_valid, wr_last);
      rd_cand = rr_pick(rd_valid, rd_last);
    end

    wr_gid   = wr_gnt[1];
    wr_gaddr = wr_gid ? wr_addr[2*ADDR_W-1:ADDR_W] : wr_addr[ADDR_W-1:0];
    wr_gdata = wr_gid ? wr_data[2*DATA_W-1:DATA_W] : wr_data[DATA_W-1:0];

    rd_cid   = rd_cand[1];
    rd_caddr = rd_cid ? rd_addr[2*ADDR_W-1:ADDR_W] : rd_addr[ADDR_W-1:0];

    // A read to the address being written this cycle would see stale data;
    // hold it one cycle so it lands after the write.
    collision = (|wr_gnt) && (|rd_cand) && (wr_gaddr == rd_caddr);
    rd_gnt    = collision ? 2'b00 : rd_cand;
  end

  // Issue outputs: all combinational from the grants, zero when idle.
  always_comb begin
    wr_ready  = wr_gnt;
    ram_ena   = |wr_gnt;
    ram_wea   = |wr_gnt;
    ram_addra = '0;
    ram_dina  = '0;
    if (|wr_gnt) begin
      ram_addra = wr_gaddr;
      ram_dina  = wr_gdata;
    end

    rd_ready  = rd_gnt;
    ram_enb   = |rd_gnt;
    ram_addrb = '0;
    if (|rd_gnt) ram_addrb = rd_caddr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_last <= 1'b1;
      rd_last <= 1'b1;
    end else begin
      if (|wr_gnt) wr_last <= wr_gid;
      if (|rd_gnt) rd_last <= rd_cid;
    end
  end

  // ---- stage boundary: read issue -> tag_p[0] ... tag_p[RD_LATENCY-1] ----
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_p <= '0;
    end else begin
      tag_vld_p <= {tag_vld_p[RD_LATENCY-2:0], |rd_gnt};
    end
  end

  always_ff @(posedge clk) begin
    tag_id_p <= {tag_id_p[RD_LATENCY-2:0], rd_cid};
  end

  // ---- stage boundary: pipeline tail aligned with ram_doutb ----
  always_comb begin
    tail_vld  = tag_vld_p[RD_LATENCY-1];
    tail_id   = tag_id_p[RD_LATENCY-1];
    rd_rvalid = {tail_vld & tail_id, tail_vld & ~tail_id};
    rd_rdata  = tail_vld ? ram_doutb : '0;
  end

`ifdef SDPRAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_grant_cnt0 <= '0;
      wr_grant_cnt1 <= '0;
      rd_grant_cnt0 <= '0;
      rd_grant_cnt1 <= '0;
      collision_cnt <= '0;
    end else begin
      if (wr_gnt[0]) wr_grant_cnt0 <= sat_inc16(wr_grant_cnt0);
      if (wr_gnt[1]) wr_grant_cnt1 <= sat_inc16(wr_grant_cnt1);
      if (rd_gnt[0]) rd_grant_cnt0 <= sat_inc16(rd_grant_cnt0);
      if (rd_gnt[1]) rd_grant_cnt1 <= sat_inc16(rd_grant_cnt1);
      if (collision) collision_cnt <= sat_inc16(collision_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_sdpram_arbiter.sv
// tb_sdpram_arbiter
// Directed bench for sdpram_arbiter with a behavioural 64x32 RAM whose read
// data appears four cycles after ram_enb/ram_addrb.
module tb_sdpram_arbiter;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          wr_valid, wr_ready, rd_valid, rd_ready, rd_rvalid;
  logic [2*ADDR_W-1:0] wr_addr, rd_addr;
  logic [2*DATA_W-1:0] wr_data;
  logic [DATA_W-1:0]   rd_rdata, ram_dina, ram_doutb;
  logic                ram_ena, ram_wea, ram_enb;
  logic [ADDR_W-1:0]   ram_addra, ram_addrb;
`ifdef SDPRAM_ARB_STATS_EN
  logic [15:0] wr_grant_cnt0, wr_grant_cnt1, rd_grant_cnt0, rd_grant_cnt1, collision_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sdpram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
`ifdef SDPRAM_ARB_STATS_EN
    , .wr_grant_cnt0(wr_grant_cnt0), .wr_grant_cnt1(wr_grant_cnt1),
    .rd_grant_cnt0(rd_grant_cnt0), .rd_grant_cnt1(rd_grant_cnt1),
    .collision_cnt(collision_cnt)
`endif
  );

  // Behavioural RAM: read-before-write within an edge, 4-cycle read latency.
  logic [DATA_W-1:0] mem [64];
  logic [DATA_W-1:0] rpipe [4];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) rpipe[i] = '0;
  end
  always @(posedge clk) begin
    if (ram_enb) rpipe[0] <= mem[ram_addrb];
    rpipe[1] <= rpipe[0];
    rpipe[2] <= rpipe[1];
    rpipe[3] <= rpipe[2];
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
  end
  assign ram_doutb = rpipe[3];

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; wr_valid = 2'b00; rd_valid = 2'b00;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 2'b11; rd_valid = 2'b11;
    wr_addr = {6'd3, 6'd3}; rd_addr = {6'd3, 6'd3}; wr_data = {32'h1, 32'h2};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++; if (wr_ready !== 2'b00) begin failures++; $display("FAIL rst_wr_ready got=%b exp=00", wr_ready); end
      checks++; if (rd_ready !== 2'b00) begin failures++; $display("FAIL rst_rd_ready got=%b exp=00", rd_ready); end
      checks++; if (rd_rvalid !== 2'b00) begin failures++; $display("FAIL rst_rd_rvalid got=%b exp=00", rd_rvalid); end
      checks++; if ({ram_ena, ram_wea, ram_enb} !== 3'b000) begin failures++; $display("FAIL rst_ram_en got=%b exp=000", {ram_ena, ram_wea, ram_enb}); end
      checks++; if ({ram_addra, ram_addrb} !== 12'h000) begin failures++; $display("FAIL rst_addr got=%h exp=000", {ram_addra, ram_addrb}); end
      checks++; if ({ram_dina, rd_rdata} !== 64'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", {ram_dina, rd_rdata}); end
    end
    rst = 1'b0; wr_valid = 2'b00; rd_valid = 2'b00;
  endtask

  task automatic test_single_write();
    @(negedge clk);
    wr_valid = 2'b01; wr_addr = {6'd0, 6'd5}; wr_data = {32'h0, 32'hDEADBEEF};
    #1;
    checks++; if (wr_ready !== 2'b01) begin failures++; $display("FAIL w1_ready got=%b exp=01", wr_ready); end
    checks++; if ({ram_ena, ram_wea} !== 2'b11) begin failures++; $display("FAIL w1_en got=%b exp=11", {ram_ena, ram_wea}); end
    checks++; if (ram_addra !== 6'd5) begin failures++; $display("FAIL w1_addra got=%0d exp=5", ram_addra); end
    checks++; if (ram_dina !== 32'hDEADBEEF) begin failures++; $display("FAIL w1_dina got=%h exp=deadbeef", ram_dina); end
    @(negedge clk); wr_valid = 2'b00; #1;
    checks++; if ({ram_ena, ram_wea, wr_ready} !== 4'b0000) begin failures++; $display("FAIL w1_idle got=%b exp=0000", {ram_ena, ram_wea, wr_ready}); end
  endtask

  task automatic test_write_contention();
    logic [1:0] exp_g;
    logic [5:0] exp_a;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_valid = 2'b11; wr_addr = {6'd31, 6'd30}; wr_data = {32'h31313131, 32'h30303030};
      #1;
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (i % 2 == 0) ? 6'd30 : 6'd31;
      checks++; if (wr_ready !== exp_g) begin failures++; $display("FAIL wcont_ready[%0d] got=%b exp=%b", i, wr_ready, exp_g); end
      checks++; if (ram_addra !== exp_a) begin failures++; $display("FAIL wcont_addra[%0d] got=%0d exp=%0d", i, ram_addra, exp_a); end
    end
    @(negedge clk); wr_valid = 2'b00;
  endtask

  task automatic test_read_contention();
    logic [1:0]  exp_g, exp_rv;
    logic [31:0] exp_d;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 4) begin rd_valid = 2'b11; rd_addr = {6'd31, 6'd30}; end
      else rd_valid = 2'b00;
      #1;
      if (c < 4) begin
        exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
        checks++; if (rd_ready !== exp_g) begin failures++; $display("FAIL rcont_ready[%0d] got=%b exp=%b", c, rd_ready, exp_g); end
        checks++; if (ram_addrb !== ((c % 2 == 0) ? 6'd30 : 6'd31)) begin failures++; $display("FAIL rcont_addrb[%0d] got=%0d", c, ram_addrb); end
        exp_rv = 2'b00; exp_d = 32'h0;
      end else begin
        exp_rv = (c % 2 == 0) ? 2'b01 : 2'b10;
        exp_d  = (c % 2 == 0) ? 32'h30303030 : 32'h31313131;
      end
      checks++; if (rd_rvalid !== exp_rv) begin failures++; $display("FAIL rcont_rvalid[%0d] got=%b exp=%b", c, rd_rvalid, exp_rv); end
      checks++; if (rd_rdata !== exp_d) begin failures++; $display("FAIL rcont_rdata[%0d] got=%h exp=%h", c, rd_rdata, exp_d); end
    end
  endtask

  task automatic test_read_return();
    @(negedge clk);
    wr_valid = 2'b01; wr_addr = {6'd0, 6'd9}; wr_data = {32'h0, 32'hA5A5A5A5};
    #1;
    checks++; if (wr_ready !== 2'b01) begin failures++; $display("FAIL ret_wr_ready got=%b exp=01", wr_ready); end
    @(negedge clk); wr_valid = 2'b00;
    @(negedge clk); rd_valid = 2'b10; rd_addr = {6'd9, 6'd0};
    #1;
    checks++; if (rd_ready !== 2'b10) begin failures++; $display("FAIL ret_rd_ready got=%b exp=10", rd_ready); end
    checks++; if (ram_addrb !== 6'd9) begin failures++; $display("FAIL ret_addrb got=%0d exp=9", ram_addrb); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); rd_valid = 2'b00; #1;
      checks++; if (rd_rvalid !== ((k == 4) ? 2'b10 : 2'b00)) begin failures++; $display("FAIL ret_rvalid[+%0d] got=%b", k, rd_rvalid); end
      checks++; if (rd_rdata !== ((k == 4) ? 32'hA5A5A5A5 : 32'h0)) begin failures++; $display("FAIL ret_rdata[+%0d] got=%h", k, rd_rdata); end
    end
  endtask

  task automatic test_collision();
    @(negedge clk); wr_valid = 2'b01; wr_addr = {6'd0, 6'd12}; wr_data = {32'h0, 32'hFFFFFFFF};
    @(negedge clk); wr_valid = 2'b00;
    @(negedge clk);
    wr_valid = 2'b01; wr_addr = {6'd0, 6'd12}; wr_data = {32'h0, 32'h12345678};
    rd_valid = 2'b10; rd_addr = {6'd12, 6'd0};
    #1;
    checks++; if (wr_ready !== 2'b01) begin failures++; $display("FAIL col_wr_ready got=%b exp=01", wr_ready); end
    checks++; if (rd_ready !== 2'b00) begin failures++; $display("FAIL col_rd_ready got=%b exp=00", rd_ready); end
    checks++; if (ram_enb !== 1'b0) begin failures++; $display("FAIL col_enb got=%b exp=0", ram_enb); end
    @(negedge clk); wr_valid = 2'b00; #1;
    checks++; if (rd_ready !== 2'b10) begin failures++; $display("FAIL col_retry_ready got=%b exp=10", rd_ready); end
    checks++; if ({ram_enb, ram_addrb} !== {1'b1, 6'd12}) begin failures++; $display("FAIL col_retry_port got=%b/%0d exp=1/12", ram_enb, ram_addrb); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); rd_valid = 2'b00; #1;
      checks++; if (rd_rvalid !== ((k == 4) ? 2'b10 : 2'b00)) begin failures++; $display("FAIL col_rvalid[+%0d] got=%b", k, rd_rvalid); end
      checks++; if (rd_rdata !== ((k == 4) ? 32'h12345678 : 32'h0)) begin failures++; $display("FAIL col_rdata[+%0d] got=%h", k, rd_rdata); end
    end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rd_valid = (i == 1) ? 2'b10 : 2'b01;
      rd_addr = {6'd12, (i == 0) ? 6'd9 : 6'd5};
      #1;
      checks++; if (rd_ready !== rd_valid) begin failures++; $display("FAIL mid_rd_ready[%0d] got=%b exp=%b", i, rd_ready, rd_valid); end
    end
    @(negedge clk); rd_valid = 2'b00; rst = 1'b1; #1;
    checks++; if (rd_rvalid !== 2'b00) begin failures++; $display("FAIL mid_rvalid_rst got=%b exp=00", rd_rvalid); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); rst = 1'b0; #1;
      checks++; if (rd_rvalid !== 2'b00) begin failures++; $display("FAIL mid_rvalid[%0d] got=%b exp=00", k, rd_rvalid); end
      checks++; if (rd_rdata !== 32'h0) begin failures++; $display("FAIL mid_rdata[%0d] got=%h exp=0", k, rd_rdata); end
    end
    @(negedge clk);
    wr_valid = 2'b11; wr_addr = {6'd41, 6'd40}; wr_data = {32'h41, 32'h40};
    rd_valid = 2'b11; rd_addr = {6'd51, 6'd50};
    #1;
    checks++; if (wr_ready !== 2'b01) begin failures++; $display("FAIL mid_wr_ptr got=%b exp=01", wr_ready); end
    checks++; if (rd_ready !== 2'b01) begin failures++; $display("FAIL mid_rd_ptr got=%b exp=01", rd_ready); end
    @(negedge clk); wr_valid = 2'b00; rd_valid = 2'b00;
  endtask

  initial begin
    rst = 1'b1; wr_valid = 2'b00; rd_valid = 2'b00;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    test_reset();
    test_single_write();
    test_write_contention();
    test_read_contention();
    test_read_return();
    test_collision();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
